// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared constants, fetch state encoding and helpers for the IF stage
package instr_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH         = 2'd0,
    MISS_WAIT     = 2'd1,
    MISS_REDIRECT = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_pipeline_reg.sv
// rtl/if_id_pipeline_reg.sv - IF/ID register with load, hold and bubble controls
module if_id_pipeline_reg
  import instr_fetch_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LOAD,
  input  logic        BUBBLE,
  input  logic [31:0] PC,
  input  logic [31:0] INSTR,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC_PLUS4,
  output logic [31:0] IF_ID_INSTR,
  output logic        IF_ID_VALID
);

  // A bubble keeps the PC fields so the stage still reports a sane address.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      IF_ID_PC       <= 32'h0000_0000;
      IF_ID_PC_PLUS4 <= 32'h0000_0004;
      IF_ID_INSTR    <= NOP_INSTR;
      IF_ID_VALID    <= 1'b0;
    end else if (BUBBLE) begin
      IF_ID_INSTR    <= NOP_INSTR;
      IF_ID_VALID    <= 1'b0;
    end else if (LOAD) begin
      IF_ID_PC       <= PC;
      IF_ID_PC_PLUS4 <= PC + 32'd4;
      IF_ID_INSTR    <= INSTR;
      IF_ID_VALID    <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, miss/redirect FSM and fetch counters for the RV32IM IF stage
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] ICACHE_INSTRUCTION,
  input  logic        ICACHE_BUSYWAIT,
  output logic [31:0] ICACHE_ADDR,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC_PLUS4,
  output logic [31:0] IF_ID_INSTR,
  output logic        IF_ID_VALID,
  output logic        FETCH_MISALIGN,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] STALL_COUNT
);

  fetch_state_t state, next_state;
  logic [31:0]  pc, next_pc, pend_target, next_pend, redirect_target;
  logic         load, bubble, accept_redirect;

  assign ICACHE_ADDR     = pc;
  assign redirect_target = align_word(BRANCH_TARGET);

  // MISS_WAIT with the line refilled behaves exactly like FETCH, so both share one arm.
  always_comb begin
    next_state      = state;
    next_pc         = pc;
    next_pend       = pend_target;
    load            = 1'b0;
    bubble          = 1'b0;
    accept_redirect = 1'b0;
    case (state)
      MISS_REDIRECT: begin
        bubble = 1'b1;
        if (BRANCH_TAKEN) begin
          accept_redirect = 1'b1;
          if (ICACHE_BUSYWAIT) begin
            next_pend = redirect_target;
          end else begin
            next_pc    = redirect_target;
            next_state = FETCH;
          end
        end else if (!ICACHE_BUSYWAIT) begin
          next_pc    = pend_target;
          next_state = FETCH;
        end
      end
      default: begin
        if (BRANCH_TAKEN) begin
          accept_redirect = 1'b1;
          bubble          = 1'b1;
          if (ICACHE_BUSYWAIT) begin
            next_pend  = redirect_target;
            next_state = MISS_REDIRECT;
          end else begin
            next_pc    = redirect_target;
            next_state = FETCH;
          end
        end else if (ICACHE_BUSYWAIT) begin
          next_state = MISS_WAIT;
          bubble     = !STALL;
        end else begin
          next_state = FETCH;
          if (!STALL) begin
            load    = 1'b1;
            next_pc = pc + 32'd4;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      pend_target    <= 32'h0000_0000;
      FETCH_MISALIGN <= 1'b0;
      FETCH_COUNT    <= 32'h0000_0000;
      STALL_COUNT    <= 32'h0000_0000;
    end else begin
      state          <= next_state;
      pc             <= next_pc;
      pend_target    <= next_pend;
      FETCH_MISALIGN <= accept_redirect && (BRANCH_TARGET[1:0] != 2'b00);
      FETCH_COUNT    <= FETCH_COUNT + {31'd0, load};
      STALL_COUNT    <= STALL_COUNT + {31'd0, ICACHE_BUSYWAIT};
    end
  end

  if_id_pipeline_reg u_if_id (
    .CLK            (CLK),
    .RESET          (RESET),
    .LOAD           (load),
    .BUBBLE         (bubble),
    .PC             (pc),
    .INSTR          (ICACHE_INSTRUCTION),
    .IF_ID_PC       (IF_ID_PC),
    .IF_ID_PC_PLUS4 (IF_ID_PC_PLUS4),
    .IF_ID_INSTR    (IF_ID_INSTR),
    .IF_ID_VALID    (IF_ID_VALID)
  );

endmodule
